// File: rtl/trace_line_parser.sv
// Parses ASCII memory-trace lines into {wr, addr} entries
// and buffers them in a show-ahead FIFO with a valid/ready handshake.
module trace_line_parser #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [7:0]        in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_wr,
    output logic [CNT_W-1:0]  line_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int NDIG = ADDR_W / 4;
    localparam int DW   = $clog2(NDIG + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] NDIG_C  = DW'(NDIG);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_OP,
        S_SEP1,
        S_SEP,
        S_ZERO,
        S_HEX,
        S_TAIL,
        S_SKIP
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [DW-1:0]     ndig_q, ndig_d;
    logic              wr_q, wr_d;

    logic is_sp, is_lf, is_cr, is_rd, is_wr, is_x, is_hex;
    logic [3:0] hex_val;
    logic commit, bad;

    logic [ADDR_W:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     cnt_q;
    logic            pop, room, push, drop;
    logic [ADDR_W:0] head;

    // Classify the incoming byte
    always_comb begin
        is_sp   = (in_byte == 8'h20) || (in_byte == 8'h09);
        is_lf   = (in_byte == 8'h0A);
        is_cr   = (in_byte == 8'h0D);
        is_rd   = in_byte inside {8'h30, 8'h52, 8'h72};
        is_wr   = in_byte inside {8'h31, 8'h57, 8'h77};
        is_x    = in_byte inside {8'h78, 8'h58};
        is_hex  = 1'b0;
        hex_val = 4'h0;
        unique case (1'b1)
            (in_byte >= 8'h30 && in_byte <= 8'h39): begin
                is_hex  = 1'b1;
                hex_val = in_byte[3:0];
            end
            (in_byte >= 8'h41 && in_byte <= 8'h46),
            (in_byte >= 8'h61 && in_byte <= 8'h66): begin
                is_hex  = 1'b1;
                hex_val = in_byte[3:0] + 4'd9;
            end
            default: begin
                is_hex  = 1'b0;
                hex_val = 4'h0;
            end
        endcase
    end

    // Line grammar next-state, accumulator and commit/error pulses
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        wr_d    = wr_q;
        commit  = 1'b0;
        bad     = 1'b0;
        if (in_en && !is_cr) begin
            unique case (state_q)
                S_OP: begin
                    if (is_rd || is_wr) begin
                        wr_d    = is_wr;
                        state_d = S_SEP1;
                    end else if (!is_sp && !is_lf) begin
                        bad = 1'b1;
                    end
                end
                S_SEP1: begin
                    if (is_sp) state_d = S_SEP;
                    else       bad = 1'b1;
                end
                S_SEP: begin
                    if (is_sp) begin
                        state_d = S_SEP;
                    end else if (is_hex) begin
                        acc_d   = ADDR_W'(hex_val);
                        ndig_d  = DW'(1);
                        state_d = (hex_val == 4'h0) ? S_ZERO : S_HEX;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_ZERO: begin
                    if (is_x) begin
                        acc_d   = '0;
                        ndig_d  = '0;
                        state_d = S_HEX;
                    end else if (is_hex) begin
                        acc_d   = (acc_q << 4) | ADDR_W'(hex_val);
                        ndig_d  = ndig_q + 1'b1;
                        state_d = S_HEX;
                    end else if (is_sp) begin
                        state_d = S_TAIL;
                    end else if (is_lf) begin
                        commit  = 1'b1;
                        state_d = S_OP;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_HEX: begin
                    if (is_hex) begin
                        if (ndig_q == NDIG_C) begin
                            bad = 1'b1;
                        end else begin
                            acc_d  = (acc_q << 4) | ADDR_W'(hex_val);
                            ndig_d = ndig_q + 1'b1;
                        end
                    end else if (is_sp && ndig_q != '0) begin
                        state_d = S_TAIL;
                    end else if (is_lf && ndig_q != '0) begin
                        commit  = 1'b1;
                        state_d = S_OP;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_TAIL: begin
                    if (is_lf) begin
                        commit  = 1'b1;
                        state_d = S_OP;
                    end else if (!is_sp) begin
                        bad = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (is_lf) state_d = S_OP;
                end
                default: state_d = S_OP;
            endcase
            if (bad) state_d = is_lf ? S_OP : S_SKIP;
        end
    end

    // Parser state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP;
            acc_q   <= '0;
            ndig_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            wr_q    <= wr_d;
        end
    end

    assign pop  = out_valid && out_ready;
    assign room = (cnt_q < DEPTH_C) || pop;
    assign push = commit && room;
    assign drop = commit && !room;
    assign head = mem_q[rd_ptr_q];

    assign out_valid = (cnt_q != '0);
    assign out_addr  = out_valid ? head[ADDR_W-1:0] : '0;
    assign out_wr    = out_valid && head[ADDR_W];

    // Entry storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_q, acc_q};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Saturating status counters
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && line_cnt != '1) line_cnt <= line_cnt + 1'b1;
            if (bad  && err_cnt  != '1) err_cnt  <= err_cnt + 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_line_parser.sv
// Bench for trace_line_parser: directed scenarios plus randomized
// traffic against a line-level grammar model and a queue FIFO model.
module tb_trace_line_parser;

    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_en = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic          out_wr;
    logic [CW-1:0] line_cnt, err_cnt, drop_cnt;

    trace_line_parser #(
        .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_wr(out_wr),
        .line_cnt(line_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [AW:0] mq[$];
    string cur = "";
    int line_m = 0, err_m = 0, drop_m = 0;

    function automatic bit is_sp(input byte c);
        return (c == 8'h20) || (c == 8'h09);
    endfunction

    function automatic int hexv(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // 0 = blank, 1 = well formed, 2 = malformed
    function automatic int classify(input string s, output bit wr,
                                    output logic [AW-1:0] addr);
        int i = 0;
        int n = 0;
        byte c;
        wr = 1'b0;
        addr = '0;
        while (i < s.len() && is_sp(s[i])) i++;
        if (i == s.len()) return 0;
        c = s[i];
        if (c == 8'h30 || c == 8'h52 || c == 8'h72) wr = 1'b0;
        else if (c == 8'h31 || c == 8'h57 || c == 8'h77) wr = 1'b1;
        else return 2;
        i++;
        if (i >= s.len() || !is_sp(s[i])) return 2;
        while (i < s.len() && is_sp(s[i])) i++;
        if (i + 1 < s.len() && s[i] == 8'h30 &&
            (s[i+1] == 8'h78 || s[i+1] == 8'h58)) i += 2;
        while (i < s.len() && hexv(s[i]) >= 0) begin
            addr = (addr << 4) | AW'(hexv(s[i]));
            n++;
            i++;
        end
        if (n == 0 || n > AW / 4) return 2;
        while (i < s.len() && is_sp(s[i])) i++;
        if (i != s.len()) return 2;
        return 1;
    endfunction

    // One clock: watch the head against the model, drive, advance the model
    task automatic step(input bit en, input byte b, input bit rdy);
        bit pop;
        bit w;
        logic [AW-1:0] a;
        logic [AW:0] exp_head;
        int k;
        @(negedge clk);
        exp_head = (mq.size() != 0) ? mq[0] : '0;
        n_chk++;
        if (out_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL mon_valid: got %b expected %b", out_valid, mq.size() != 0);
        end
        n_chk++;
        if ({out_wr, out_addr} !== exp_head) begin
            n_fail++;
            $display("FAIL mon_head: got %b/%h expected %b/%h",
                     out_wr, out_addr, exp_head[AW], exp_head[AW-1:0]);
        end
        in_en = en;
        in_byte = b;
        out_ready = rdy;
        @(posedge clk);
        pop = rdy && (mq.size() != 0);
        k = 0;
        w = 1'b0;
        a = '0;
        if (en && b != 8'h0D) begin
            if (b == 8'h0A) begin
                k = classify(cur, w, a);
                cur = "";
            end else begin
                cur = $sformatf("%s%c", cur, b);
            end
        end
        if (k == 2 && err_m < CMAX) err_m++;
        if (pop) void'(mq.pop_front());
        if (k == 1) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({w, a});
                if (line_m < CMAX) line_m++;
            end else if (drop_m < CMAX) begin
                drop_m++;
            end
        end
        #1;
    endtask

    task automatic feed(input string s, input bit rdy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        in_en = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        cur = "";
        line_m = 0;
        err_m = 0;
        drop_m = 0;
    endtask

    task automatic test_reset();
        rst_pulse();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_chk++; if (out_addr !== '0) begin n_fail++;
            $display("FAIL rst_addr: got %h expected 0", out_addr); end
        n_chk++; if (out_wr !== 1'b0) begin n_fail++;
            $display("FAIL rst_wr: got %b expected 0", out_wr); end
        n_chk++; if (line_cnt !== '0) begin n_fail++;
            $display("FAIL rst_line: got %0d expected 0", line_cnt); end
        n_chk++; if (err_cnt !== '0) begin n_fail++;
            $display("FAIL rst_err: got %0d expected 0", err_cnt); end
        n_chk++; if (drop_cnt !== '0) begin n_fail++;
            $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_basic();
        rst_pulse();
        feed("R 1A2B\n", 1'b1);
        n_chk++; if (out_valid !== 1'b1 || out_addr !== 32'h1A2B || out_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_head: got %b %h %b expected 1 00001a2b 0",
                     out_valid, out_addr, out_wr);
        end
        n_chk++; if (line_cnt !== 5'd1 || err_cnt !== 5'd0) begin n_fail++;
            $display("FAIL basic_cnt: got %0d/%0d expected 1/0", line_cnt, err_cnt); end
        step(1'b0, 8'h00, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL basic_pop: got %b expected 0", out_valid); end
    endtask

    task automatic test_whitespace();
        rst_pulse();
        feed("  w\t0xDEADBEEF  \r\n", 1'b0);
        n_chk++; if (out_addr !== 32'hDEADBEEF || out_wr !== 1'b1) begin n_fail++;
            $display("FAIL ws_head: got %h %b expected deadbeef 1", out_addr, out_wr); end
        n_chk++; if (line_cnt !== 5'd1) begin n_fail++;
            $display("FAIL ws_line: got %0d expected 1", line_cnt); end
    endtask

    task automatic test_errors();
        rst_pulse();
        feed("X 12\n0 5\n\n1\n", 1'b0);
        n_chk++; if (err_cnt !== 5'd2) begin n_fail++;
            $display("FAIL err_cnt: got %0d expected 2", err_cnt); end
        n_chk++; if (line_cnt !== 5'd1) begin n_fail++;
            $display("FAIL err_line: got %0d expected 1", line_cnt); end
        n_chk++; if (out_addr !== 32'h5 || out_wr !== 1'b0) begin n_fail++;
            $display("FAIL err_head: got %h %b expected 5 0", out_addr, out_wr); end
        step(1'b0, 8'h00, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL err_single: got %b expected 0", out_valid); end
    endtask

    task automatic test_digits();
        rst_pulse();
        feed("1 123456789\n", 1'b0);
        n_chk++; if (err_cnt !== 5'd1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL dig_over: got err %0d valid %b expected 1 0", err_cnt, out_valid); end
        feed("1 F\n", 1'b0);
        n_chk++; if (out_addr !== 32'hF || out_wr !== 1'b1 || line_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL dig_next: got %h %b %0d expected f 1 1",
                     out_addr, out_wr, line_cnt);
        end
    endtask

    task automatic test_full();
        rst_pulse();
        for (int i = 0; i <= DEPTH; i++) feed($sformatf("0 %0h\n", i), 1'b0);
        n_chk++; if (line_cnt !== 5'd16 || drop_cnt !== 5'd1) begin n_fail++;
            $display("FAIL full_cnt: got %0d/%0d expected 16/1", line_cnt, drop_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++; if (out_valid !== 1'b1 || out_addr !== AW'(i)) begin n_fail++;
                $display("FAIL full_order: got %b %h expected 1 %h", out_valid, out_addr, i); end
            step(1'b0, 8'h00, 1'b1);
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL full_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_pop();
        rst_pulse();
        for (int i = 0; i < DEPTH; i++) feed($sformatf("0 %0h\n", i), 1'b0);
        feed("0 ABC", 1'b0);
        step(1'b1, 8'h0A, 1'b1);
        n_chk++; if (drop_cnt !== 5'd0 || line_cnt !== 5'd17) begin n_fail++;
            $display("FAIL fpop_cnt: got %0d/%0d expected 0/17", drop_cnt, line_cnt); end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [AW-1:0] e;
            e = (i == DEPTH) ? 32'hABC : AW'(i);
            n_chk++; if (out_valid !== 1'b1 || out_addr !== e) begin n_fail++;
                $display("FAIL fpop_order: got %b %h expected 1 %h", out_valid, out_addr, e); end
            step(1'b0, 8'h00, 1'b1);
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL fpop_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midline();
        rst_pulse();
        feed("1 AB", 1'b0);
        rst_pulse();
        feed("0 C\n", 1'b0);
        n_chk++; if (out_addr !== 32'hC || out_wr !== 1'b0) begin n_fail++;
            $display("FAIL mid_head: got %h %b expected c 0", out_addr, out_wr); end
        n_chk++; if (line_cnt !== 5'd1 || err_cnt !== 5'd0 || drop_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_cnt: got %0d/%0d/%0d expected 1/0/0",
                     line_cnt, err_cnt, drop_cnt);
        end
        step(1'b0, 8'h00, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL mid_single: got %b expected 0", out_valid); end
    endtask

    function automatic string pick(input string set, input int n);
        string s = "";
        for (int i = 0; i < n; i++)
            s = $sformatf("%s%c", s, set[$urandom_range(0, set.len() - 1)]);
        return s;
    endfunction

    function automatic string gen_line();
        string s;
        int kind;
        int nd;
        kind = $urandom_range(0, 9);
        if (kind == 0) return pick(" \t", $urandom_range(0, 3));
        if (kind == 1) return pick(" \t01RWxX5zG", $urandom_range(1, 6));
        s = pick(" \t", $urandom_range(0, 2));
        s = {s, pick(($urandom_range(0, 9) == 0) ? "Qq#" : "01RrWw", 1)};
        s = {s, pick(" \t", ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2))};
        case ($urandom_range(0, 2))
            0: s = {s, "0x"};
            1: s = {s, "0X"};
            default: s = s;
        endcase
        nd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : $urandom_range(1, 8);
        s = {s, pick("0123456789abcdefABCDEF", nd)};
        s = {s, pick(" \t", $urandom_range(0, 2))};
        return s;
    endfunction

    task automatic test_random();
        string s;
        bit hold;
        rst_pulse();
        for (int l = 0; l < 250; l++) begin
            s = gen_line();
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < s.len(); i++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 8'($urandom), !hold && $urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) == 0)
                    step(1'b1, 8'h0D, !hold && $urandom_range(0, 1) == 1);
                step(1'b1, s[i], !hold && $urandom_range(0, 1) == 1);
            end
            step(1'b1, 8'h0A, !hold && $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
        n_chk++; if (out_valid !== 1'b0 || mq.size() != 0) begin n_fail++;
            $display("FAIL rnd_drain: got valid %b model %0d expected 0 0", out_valid, mq.size()); end
        n_chk++; if (line_cnt !== CW'(line_m)) begin n_fail++;
            $display("FAIL rnd_line: got %0d expected %0d", line_cnt, line_m); end
        n_chk++; if (err_cnt !== CW'(err_m)) begin n_fail++;
            $display("FAIL rnd_err: got %0d expected %0d", err_cnt, err_m); end
        n_chk++; if (drop_cnt !== CW'(drop_m)) begin n_fail++;
            $display("FAIL rnd_drop: got %0d expected %0d", drop_cnt, drop_m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_whitespace();
        test_errors();
        test_digits();
        test_full();
        test_full_pop();
        test_reset_midline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_line_parser.md
Name: trace_line_parser

Overview:
Consumes the byte stream from sd_file_reader (outen/outbyte) carrying an ASCII memory-trace file such as art.trace. Parses each text line into an access flag and a binary address. Buffers parsed entries in a small FIFO with a valid/ready handshake, so the downstream LRU cache model can consume them at its own pace. The input side has no backpressure, because the SD reader cannot stall; when the FIFO is full, new entries are dropped and counted.

Parameters:
ADDR_W, 32, address width in bits; multiple of 4; at most ADDR_W/4 hex digits are accepted per line
FIFO_DEPTH, 16, number of parsed entries buffered; power of 2, at least 2
CNT_W, 16, width of the status counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_en  in  1  byte strobe from the file reader; one byte per cycle when high
in_byte  in  8  file byte, valid when in_en=1
out_valid  out  1  FIFO head entry is valid
out_ready  in  1  consumer accepts the head entry when out_valid and out_ready are both high
out_addr  out  ADDR_W  address of the head entry, zero-extended
out_wr  out  1  head entry access type: 1=write, 0=read
line_cnt  out  CNT_W  count of lines pushed into the FIFO, saturating
err_cnt  out  CNT_W  count of malformed lines, saturating
drop_cnt  out  CNT_W  count of well-formed lines lost because the FIFO was full, saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; out_valid=0, out_addr=0, out_wr=0.
  - All counters set to 0; FSM goes to S_OP; address accumulator and digit count cleared.
  - Reset in mid-line discards the partial line; parsing restarts at the next byte.
- Line grammar: [sp]* OP sp+ ["0x"|"0X"] HEX{1..ADDR_W/4} [sp]* LF.
  - sp is space (0x20) or tab (0x09).
  - OP is '0'/'R'/'r' (read) or '1'/'W'/'w' (write).
  - HEX is 0-9, a-f, A-F.
  - CR (0x0D) is ignored in every state.
- Bytes are processed only on cycles with in_en=1; other cycles leave the FSM unchanged.
- FSM states:
  - S_OP:
    - sp: stay.
    - LF: blank line; ignored, not an error.
    - OP: latch wr, go to S_SEP1.
    - Any other byte: error.
  - S_SEP1 (at least one sp required):
    - sp: go to S_SEP.
    - Any other byte (including LF): error.
  - S_SEP:
    - sp: stay.
    - '0': acc=0, ndig=1, go to S_ZERO.
    - Other hex digit: acc=digit, ndig=1, go to S_HEX.
    - Any other byte (including LF): error.
  - S_ZERO:
    - 'x'/'X': acc=0, ndig=0, go to S_HEX.
    - Hex digit: accumulate, go to S_HEX.
    - sp: go to S_TAIL.
    - LF: commit (address 0).
    - Any other byte: error.
  - S_HEX:
    - Hex digit: if ndig==ADDR_W/4, error; else acc = (acc<<4)|digit, ndig++.
    - sp: if ndig≥1 go to S_TAIL, else error.
    - LF: if ndig≥1 commit, else error.
    - Any other byte: error.
  - S_TAIL:
    - sp: stay.
    - LF: commit.
    - Any other byte: error.
  - S_SKIP:
    - LF: go to S_OP.
    - Any other byte: stay.
- Error handling:
  - err_cnt increments by 1 per malformed line.
  - If the offending byte is LF, go directly to S_OP; otherwise go to S_SKIP.
  - Only one increment per line, even though S_SKIP absorbs further bad bytes.
- Commit, performed in the same cycle the LF is sampled; FSM returns to S_OP:
  - If the FIFO has room, push {wr, acc} and increment line_cnt.
  - Otherwise increment drop_cnt; the entry is discarded.
  - "Room" means count < FIFO_DEPTH, or a pop happens in the same cycle. Push and pop in the same cycle on a full FIFO are both accepted.
- Latency: entry written at the clk edge that samples LF; out_valid=1 from the next cycle. out_addr and out_wr are driven from the FIFO head (show-ahead).
- Handshake:
  - Pop occurs at an edge where out_valid=1 and out_ready=1.
  - out_addr/out_wr are stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- FIFO order is strict first-in, first-out; read and write pointers wrap modulo FIFO_DEPTH.
- Counters saturate at all-ones and never wrap.
- A final line without a trailing LF is never committed.

Test Plan:
- "R 1A2B\n", out_ready=1 -> out_valid one cycle after LF with out_addr=0x00001A2B, out_wr=0; line_cnt=1; err_cnt=0.
- "  w\t0xDEADBEEF  \r\n" -> out_addr=0xDEADBEEF, out_wr=1; line_cnt=1.
- "X 12\n0 5\n\n1\n" -> err_cnt=2 (bad op; missing address); exactly one entry, addr 0x5 with wr=0; the blank line is not counted.
- "1 123456789\n" with ADDR_W=32 -> err_cnt=1; no entry; the next line "1 F\n" yields addr 0xF, wr=1.
- out_ready=0, 17 lines "0 0..0 10", in_en every cycle -> 16 entries held, drop_cnt=1, line_cnt=16. Then out_ready=1 -> addresses 0x0..0xF pop in order. Also: pop on the same cycle as LF on a full FIFO accepts the push with drop_cnt unchanged.
- Feed "1 AB", assert rst for 1 cycle, release, feed "0 C\n" -> single entry addr 0xC, wr=0; all counters show only post-reset activity.
